// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 16-bit WISC core: ID decode, ID/EX-EX/MEM-MEM/WB control pipeline,
// hazard stall/flush, EX forwarding selects and sticky halt. Define FWD_EN to enable forwarding.
module pipe_ctrl_unit #(
  parameter int OP_W    = 4,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_opcode,
  input  logic [REG_W-1:0]   id_src1,
  input  logic [REG_W-1:0]   id_src2,
  input  logic [REG_W-1:0]   id_dst,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_is_branch,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_W-1:0]   wb_dst,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               halt
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               is_branch;
    logic               is_hlt;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam int    CTRL_W   = 7 + ALUOP_W;
  localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  function automatic ctrl_t decode(input logic [3:0] op, input logic [REG_W-1:0] dst);
    ctrl_t c;
    c        = CTRL_NOP;
    c.alu_op = op[ALUOP_W-1:0];
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: c.reg_write = 1'b1;
      4'b0100, 4'b0101, 4'b0110: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      4'b1000: begin
        c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
        c.alu_src   = 1'b1; c.alu_op   = {ALUOP_W{1'b0}};
      end
      4'b1001: begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = {ALUOP_W{1'b0}}; end
      4'b1010, 4'b1011, 4'b1110: c.reg_write = 1'b1;
      4'b1100, 4'b1101: c.is_branch = 1'b1;
      4'b1111: c.is_hlt = 1'b1;
      default: c = CTRL_NOP;
    endcase
    // r0 is hardwired zero, so a write to it is no write at all
    if (dst == REG_ZERO) c.reg_write = 1'b0;
    else                 c.reg_write = c.reg_write;
    return c;
  endfunction

  function automatic logic hit(input logic v, input logic rw, input logic [REG_W-1:0] d,
                               input logic u1, input logic u2,
                               input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2);
    return v & rw & (d != REG_ZERO) & ((u1 & (d == s1)) | (u2 & (d == s2)));
  endfunction

  logic             id_ok_s, id_use1_s, id_use2_s;
  logic [3:0]       id_op_s;
  ctrl_t            id_ctrl_s;
  logic             haz_ex_s, haz_mem_s, hold_s, flush_s, stall_s;

  logic             ex_valid_r;
  ctrl_t            ex_ctrl_r;
  logic [REG_W-1:0] ex_dst_r;
  logic             mem_valid_r, mem_reg_write_r, mem_read_r, mem_write_r, mem_to_reg_r, mem_hlt_r;
  logic [REG_W-1:0] mem_dst_r;
  logic             wb_valid_r, wb_reg_write_r, wb_mem_to_reg_r;
  logic [REG_W-1:0] wb_dst_r;
  logic             halt_r;

  assign id_op_s = id_opcode[3:0];
  assign id_ok_s = id_valid & ((id_opcode >> 3'd4) == {OP_W{1'b0}});

  // ID decode of the control bundle and source usage
  always_comb begin
    id_ctrl_s = CTRL_NOP;
    id_use1_s = 1'b0;
    id_use2_s = 1'b0;
    if (id_ok_s) begin
      id_ctrl_s = decode(id_op_s, id_dst);
      id_use1_s = !(id_op_s == 4'b1100 || id_op_s == 4'b1110 || id_op_s == 4'b1111);
      id_use2_s = (id_op_s <= 4'b0011) || id_op_s == 4'b0111 || id_op_s == 4'b1001;
    end else begin
      id_ctrl_s = CTRL_NOP;
    end
  end

  assign haz_ex_s  = hit(ex_valid_r, ex_ctrl_r.reg_write, ex_dst_r,
                         id_use1_s, id_use2_s, id_src1, id_src2);
  assign haz_mem_s = hit(mem_valid_r, mem_reg_write_r, mem_dst_r,
                         id_use1_s, id_use2_s, id_src1, id_src2);
`ifdef FWD_EN
  assign hold_s = ex_ctrl_r.mem_read & haz_ex_s;
`else
  assign hold_s = haz_ex_s | haz_mem_s;
`endif
  // gating with rst_n keeps flush low while reset is held
  assign flush_s = ex_branch_taken & rst_n;
  assign stall_s = halt_r | (~flush_s & hold_s);
  assign flush   = flush_s;
  assign stall   = stall_s;

  // ID/EX register: bubble on stall or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0; ex_ctrl_r <= CTRL_NOP; ex_dst_r <= REG_ZERO;
    end else if (flush_s | stall_s) begin
      ex_valid_r <= 1'b0; ex_ctrl_r <= CTRL_NOP; ex_dst_r <= REG_ZERO;
    end else begin
      ex_valid_r <= id_ok_s;
      ex_ctrl_r  <= id_ctrl_s;
      ex_dst_r   <= id_ok_s ? id_dst : REG_ZERO;
    end
  end

  // EX/MEM, MEM/WB registers and sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r <= 1'b0; mem_reg_write_r <= 1'b0; mem_read_r <= 1'b0;
      mem_write_r <= 1'b0; mem_to_reg_r <= 1'b0; mem_hlt_r <= 1'b0; mem_dst_r <= REG_ZERO;
      wb_valid_r <= 1'b0; wb_reg_write_r <= 1'b0; wb_mem_to_reg_r <= 1'b0; wb_dst_r <= REG_ZERO;
      halt_r <= 1'b0;
    end else begin
      mem_valid_r     <= ex_valid_r;
      mem_reg_write_r <= ex_ctrl_r.reg_write;
      mem_read_r      <= ex_ctrl_r.mem_read;
      mem_write_r     <= ex_ctrl_r.mem_write;
      mem_to_reg_r    <= ex_ctrl_r.mem_to_reg;
      mem_hlt_r       <= ex_ctrl_r.is_hlt;
      mem_dst_r       <= ex_dst_r;
      wb_valid_r      <= mem_valid_r;
      wb_reg_write_r  <= mem_reg_write_r;
      wb_mem_to_reg_r <= mem_to_reg_r;
      wb_dst_r        <= mem_dst_r;
      halt_r          <= halt_r | (mem_valid_r & mem_hlt_r);
    end
  end

  assign ex_alu_op     = ex_valid_r  ? ex_ctrl_r.alu_op    : {ALUOP_W{1'b0}};
  assign ex_alu_src    = ex_valid_r  & ex_ctrl_r.alu_src;
  assign ex_is_branch  = ex_valid_r  & ex_ctrl_r.is_branch;
  assign mem_read      = mem_valid_r & mem_read_r;
  assign mem_write     = mem_valid_r & mem_write_r;
  assign wb_reg_write  = wb_valid_r  & wb_reg_write_r;
  assign wb_mem_to_reg = wb_valid_r  & wb_mem_to_reg_r;
  assign wb_dst        = wb_valid_r  ? wb_dst_r : REG_ZERO;
  assign halt          = halt_r;

`ifdef FWD_EN
  logic [REG_W-1:0] ex_src1_r, ex_src2_r;

  function automatic logic [1:0] fsel(input logic [REG_W-1:0] src);
    if (mem_valid_r & mem_reg_write_r & (mem_dst_r != REG_ZERO) & (mem_dst_r == src)) return 2'b10;
    else if (wb_valid_r & wb_reg_write_r & (wb_dst_r != REG_ZERO) & (wb_dst_r == src)) return 2'b01;
    else return 2'b00;
  endfunction

  // EX source fields, zeroed in bubbles so they never match a writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_src1_r <= REG_ZERO; ex_src2_r <= REG_ZERO;
    end else if (flush_s | stall_s | ~id_ok_s) begin
      ex_src1_r <= REG_ZERO; ex_src2_r <= REG_ZERO;
    end else begin
      ex_src1_r <= id_src1; ex_src2_r <= id_src2;
    end
  end

  assign fwd_a = fsel(ex_src1_r);
  assign fwd_b = fsel(ex_src2_r);
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed test-plan steps plus randomized traffic
// checked against an instruction-level model of the three downstream stages.
module tb_pipe_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst_n, id_valid, ex_branch_taken;
  logic [3:0] id_opcode, id_src1, id_src2, id_dst;
  logic       stall, flush, ex_alu_src, ex_is_branch, mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg, halt;
  logic [2:0] ex_alu_op;
  logic [3:0] wb_dst;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush(flush), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_is_branch(ex_is_branch), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halt(halt)
  );

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
  localparam int LU_STALLS = 1, RAW_STALLS = 0;
  localparam logic [1:0] LU_FWD = 2'b01, RAW_FWD = 2'b10;
`else
  localparam bit FWD = 1'b0;
  localparam int LU_STALLS = 2, RAW_STALLS = 2;
  localparam logic [1:0] LU_FWD = 2'b00, RAW_FWD = 2'b00;
`endif

  typedef struct { bit v; bit [3:0] op, s1, s2, d; } inst_t;
  inst_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  bit    mhalt;
  int    checks = 0, failures = 0;

  function automatic bit wr(inst_t i);
    return i.v && i.d != 0 && (i.op < 8 || i.op == 8 || i.op == 10 || i.op == 11 || i.op == 14);
  endfunction
  function automatic bit u1(bit [3:0] op); return !(op == 12 || op == 14 || op == 15); endfunction
  function automatic bit u2(bit [3:0] op); return op < 4 || op == 7 || op == 9; endfunction
  function automatic bit haz(inst_t s);
    return id_valid && wr(s) && ((u1(id_opcode) && s.d == id_src1) || (u2(id_opcode) && s.d == id_src2));
  endfunction
  function automatic bit m_flush(); return rst_n && ex_branch_taken; endfunction
  function automatic bit m_stall();
    bit h;
    h = FWD ? (pipe[0].v && pipe[0].op == 8 && haz(pipe[0])) : (haz(pipe[0]) || haz(pipe[1]));
    return mhalt || (!m_flush() && h);
  endfunction
  function automatic logic [1:0] fsel(bit [3:0] src);
    if (!FWD || !pipe[0].v) return 2'b00;
    if (wr(pipe[1]) && pipe[1].d == src) return 2'b10;
    if (wr(pipe[2]) && pipe[2].d == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
    mhalt = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    inst_t e, m, w;
    logic [2:0] aop;
    e = pipe[0]; m = pipe[1]; w = pipe[2];
    aop = (!e.v || e.op == 8 || e.op == 9) ? 3'd0 : e.op[2:0];
    chk("ex_alu_op", {5'd0, ex_alu_op}, {5'd0, aop});
    chk("ex_alu_src", {7'd0, ex_alu_src}, {7'd0, e.v && (e.op == 8 || e.op == 9 || (e.op >= 4 && e.op <= 6))});
    chk("ex_is_branch", {7'd0, ex_is_branch}, {7'd0, e.v && (e.op == 12 || e.op == 13)});
    chk("mem_read", {7'd0, mem_read}, {7'd0, m.v && m.op == 8});
    chk("mem_write", {7'd0, mem_write}, {7'd0, m.v && m.op == 9});
    chk("wb_reg_write", {7'd0, wb_reg_write}, {7'd0, wr(w)});
    chk("wb_mem_to_reg", {7'd0, wb_mem_to_reg}, {7'd0, w.v && w.op == 8});
    chk("wb_dst", {4'd0, wb_dst}, {4'd0, w.v ? w.d : 4'd0});
    chk("fwd_a", {6'd0, fwd_a}, {6'd0, fsel(e.s1)});
    chk("fwd_b", {6'd0, fwd_b}, {6'd0, fsel(e.s2)});
    chk("halt", {7'd0, halt}, {7'd0, mhalt});
    chk("stall", {7'd0, stall}, {7'd0, m_stall()});
    chk("flush", {7'd0, flush}, {7'd0, m_flush()});
  endtask

  task automatic at_neg(); @(negedge clk); check_all(); endtask

  task automatic at_pos();
    bit bub;
    bub = m_flush() || m_stall() || !id_valid;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (pipe[1].v && pipe[1].op == 15) mhalt = 1'b1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (bub) pipe[0] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
      else     pipe[0] = '{1'b1, id_opcode, id_src1, id_src2, id_dst};
    end
    #1;
  endtask

  // present one instruction, holding it while the pipeline stalls; counts observed stall cycles
  task automatic issue(input logic [3:0] op, s1, s2, d, output int ns);
    bit held;
    id_valid = 1'b1; id_opcode = op; id_src1 = s1; id_src2 = s2; id_dst = d;
    ns = 0; held = 1'b1;
    for (int k = 0; k < 6 && held; k++) begin
      at_neg();
      if (stall === 1'b1) ns++;
      held = m_stall();
      at_pos();
    end
    chk("issue_accepted", {7'd0, held}, 8'd0);
    id_valid = 1'b0;
  endtask

  task automatic drain();
    id_valid = 1'b0; ex_branch_taken = 1'b0;
    repeat (3) begin at_neg(); at_pos(); end
  endtask

  initial begin
    int  ns;
    bit  hold;
    model_reset();
    rst_n = 1'b0; ex_branch_taken = 1'b1; id_valid = 1'b1;
    id_opcode = 4'd8; id_src1 = 4'd3; id_src2 = 4'd3; id_dst = 4'd3;
    #1;
    repeat (3) begin
      at_neg();
      id_opcode = 4'($urandom); id_dst = 4'($urandom);
      at_pos();
    end
    rst_n = 1'b1; ex_branch_taken = 1'b0; id_valid = 1'b0;
    at_neg(); at_pos();

    // ADD r1,r2,r3 through the pipe
    issue(4'd0, 4'd2, 4'd3, 4'd1, ns);
    at_neg(); chk("add_ex_alu_op", {5'd0, ex_alu_op}, 8'd0);
    at_pos(); at_neg(); at_pos(); at_neg();
    chk("add_wb_reg_write", {7'd0, wb_reg_write}, 8'd1);
    chk("add_wb_dst", {4'd0, wb_dst}, 8'd1);
    at_pos(); drain();

    // load-use
    issue(4'd8, 4'd1, 4'd0, 4'd4, ns);
    issue(4'd0, 4'd4, 4'd6, 4'd5, ns);
    chk("lu_stall_cycles", 8'(ns), 8'(LU_STALLS));
    at_neg(); chk("lu_fwd_a", {6'd0, fwd_a}, {6'd0, LU_FWD});
    at_pos(); drain();

    // ALU RAW
    issue(4'd0, 4'd2, 4'd3, 4'd1, ns);
    issue(4'd1, 4'd1, 4'd1, 4'd2, ns);
    chk("raw_stall_cycles", 8'(ns), 8'(RAW_STALLS));
    at_neg();
    chk("raw_fwd_a", {6'd0, fwd_a}, {6'd0, RAW_FWD});
    chk("raw_fwd_b", {6'd0, fwd_b}, {6'd0, RAW_FWD});
    at_pos(); drain();

    // r0 writer then r0 reader
    issue(4'd0, 4'd1, 4'd2, 4'd0, ns);
    issue(4'd0, 4'd0, 4'd0, 4'd3, ns);
    chk("r0_stall_cycles", 8'(ns), 8'd0);
    at_neg(); chk("r0_fwd_a", {6'd0, fwd_a}, 8'd0);
    at_pos(); drain();

    // load-use hazard together with a taken branch
    issue(4'd8, 4'd1, 4'd0, 4'd4, ns);
    id_valid = 1'b1; id_opcode = 4'd0; id_src1 = 4'd4; id_src2 = 4'd6; id_dst = 4'd5;
    ex_branch_taken = 1'b1;
    at_neg();
    chk("br_flush", {7'd0, flush}, 8'd1);
    chk("br_stall", {7'd0, stall}, 8'd0);
    at_pos();
    ex_branch_taken = 1'b0; id_valid = 1'b0;
    at_neg(); chk("br_bubble_mem_read", {7'd0, mem_read}, 8'd1);
    at_pos(); drain();

    // randomized traffic
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        id_valid  = ($urandom_range(0, 3) != 0);
        id_opcode = 4'($urandom_range(0, 14));
        id_src1   = 4'($urandom_range(0, 7));
        id_src2   = 4'($urandom_range(0, 7));
        id_dst    = 4'($urandom_range(0, 7));
        ex_branch_taken = ($urandom_range(0, 7) == 0);
      end
      at_neg();
      hold = m_stall();
      at_pos();
    end
    drain();

    // HLT retires and halt sticks
    issue(4'd15, 4'd0, 4'd0, 4'd0, ns);
    at_neg(); chk("halt_early1", {7'd0, halt}, 8'd0);
    at_pos(); at_neg(); chk("halt_early2", {7'd0, halt}, 8'd0);
    at_pos(); at_neg(); chk("halt_set", {7'd0, halt}, 8'd1);
    at_pos();
    id_valid = 1'b1; id_opcode = 4'd0; id_src1 = 4'd1; id_src2 = 4'd2; id_dst = 4'd3;
    repeat (4) begin at_neg(); chk("halt_stall", {7'd0, stall}, 8'd1); at_pos(); end

    // asynchronous reset mid-stream
    ex_branch_taken = 1'b1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_halt", {7'd0, halt}, 8'd0);
    at_pos();
    rst_n = 1'b1; ex_branch_taken = 1'b0;
    issue(4'd10, 4'd7, 4'd0, 4'd7, ns);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
